// File: rtl/vga_stream_monitor_if.sv
// Bus bundle between a TinyVGA PMOD source and vga_stream_monitor.
// master: the video source / bench side (drives vga_in and clr_err).
// slave : the monitor side (drives timing status and frame signature).
interface vga_stream_monitor_if;
   logic [7:0]  vga_in;
   logic        clr_err;
   logic        locked;
   logic        err_h;
   logic        err_v;
   logic        err_blank;
   logic        frame_done;
   logic [15:0] frame_sig;
   logic [7:0]  frame_count;

   modport master (
      output vga_in, clr_err,
      input  locked, err_h, err_v, err_blank, frame_done, frame_sig, frame_count
   );

   modport slave (
      input  vga_in, clr_err,
      output locked, err_h, err_v, err_blank, frame_done, frame_sig, frame_count
   );
endinterface

// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor: receiver/checker for the TinyVGA PMOD video stream.
// Registers the 8-bit bus, recovers h/v counters from sync leading edges,
// verifies line/frame length and sync widths, flags non-black pixels in
// blanking while locked, and folds the active pixels of every frame into
// a 16-bit signature.
// Build option: define VGA_MON_CRC_EN to make the signature a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF, 6 bits per pixel MSB first); otherwise it is a
// plain additive sum of the 6-bit pixels mod 2^16.
module vga_stream_monitor #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BP        = 48,
   parameter int H_SYNC      = 96,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_BP        = 33,
   parameter int V_SYNC      = 2,
   parameter int V_TOTAL     = 525,
   parameter bit SYNC_ACTIVE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   vga_stream_monitor_if.slave  mon
);

   localparam logic [11:0] CNT_MAX  = 12'hFFF;
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_SW     = 12'(H_SYNC);
   localparam logic [11:0] V_SW     = 12'(V_SYNC);
   localparam logic [11:0] H_ACT_LO = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_ACT_HI = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0] V_ACT_LO = 12'(V_SYNC + V_BP);
   localparam logic [11:0] V_ACT_HI = 12'(V_SYNC + V_BP + V_ACTIVE);

   // Reset value of the input register: both syncs idle, RGB black, so the
   // cycle after reset never looks like a sync edge or a blanking error.
   localparam logic [7:0]  VGA_IDLE = {~SYNC_ACTIVE, 3'b000, ~SYNC_ACTIVE, 3'b000};

`ifdef VGA_MON_CRC_EN
   localparam logic [15:0] SIG_INIT = 16'hFFFF;

   // CRC-16-CCITT over one 6-bit pixel, MSB (R1) first, non-reflected.
   function automatic logic [15:0] sig_step(input logic [15:0] c, input logic [5:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 5; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction
`else
   localparam logic [15:0] SIG_INIT = 16'h0000;

   // Additive signature: running sum of pixel values mod 2^16.
   function automatic logic [15:0] sig_step(input logic [15:0] c, input logic [5:0] d);
      return c + {10'd0, d};
   endfunction
`endif

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state_q, state_d;

   logic [7:0]  vin_q;
   logic        hs_prev_q;
   logic        vs_prev_q, vs_prev_d;
   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] vcnt_q, vcnt_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] sig_q, sig_d;
   logic        err_h_q, err_h_d;
   logic        err_v_q, err_v_d;
   logic        err_blank_q, err_blank_d;
   logic        fd_q, fd_d;
   logic [7:0]  fc_q, fc_d;

   logic        hs, vs;
   logic        hs_lead, hs_fall;
   logic        vs_lead, vs_fall;
   logic [5:0]  pix;
   logic        active;
   logic        chk_en;
   logic        h_bad, v_bad, blank_bad;

   // Decode the registered bus: sync levels and the {R1,R0,G1,G0,B1,B0} pixel.
   assign hs  = (vin_q[7] == SYNC_ACTIVE);
   assign vs  = (vin_q[3] == SYNC_ACTIVE);
   assign pix = {vin_q[0], vin_q[4], vin_q[1], vin_q[5], vin_q[2], vin_q[6]};

   // vsync is only looked at on hsync leading edges, so the vertical edges
   // are qualified by hs_lead and compared with the value seen at the last one.
   assign hs_lead = hs & ~hs_prev_q;
   assign hs_fall = ~hs & hs_prev_q;
   assign vs_lead = hs_lead & vs & ~vs_prev_q;
   assign vs_fall = hs_lead & ~vs & vs_prev_q;

   // Current-cycle counters: 0 on the leading edge, else count up and saturate.
   always_comb begin
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      vs_prev_d = vs_prev_q;
      if (hs_lead) begin
         hcnt_d    = 12'd0;
         vs_prev_d = vs;
      end else if (hcnt_q != CNT_MAX) begin
         hcnt_d = hcnt_q + 12'd1;
      end
      if (vs_lead) begin
         vcnt_d = 12'd0;
      end else if (hs_lead && (vcnt_q != CNT_MAX)) begin
         vcnt_d = vcnt_q + 12'd1;
      end
   end

   assign active = (hcnt_d >= H_ACT_LO) && (hcnt_d < H_ACT_HI) &&
                   (vcnt_d >= V_ACT_LO) && (vcnt_d < V_ACT_HI);

   // Timing checks: the previous count closes a line/frame, the current
   // count at the first non-sync cycle/line gives the pulse width.
   assign chk_en    = (state_q != HUNT);
   assign h_bad     = chk_en && ((hs_lead && (hcnt_q != H_LAST)) ||
                                 (hs_fall && (hcnt_d != H_SW)));
   assign v_bad     = chk_en && ((vs_lead && (vcnt_q != V_LAST)) ||
                                 (vs_fall && (vcnt_d != V_SW)));
   assign blank_bad = (state_q == LOCKED) && !active && (pix != 6'd0);

   // Sticky error flags: a new error takes priority over clr_err.
   always_comb begin
      err_h_d     = h_bad     | (err_h_q     & ~mon.clr_err);
      err_v_d     = v_bad     | (err_v_q     & ~mon.clr_err);
      err_blank_d = blank_bad | (err_blank_q & ~mon.clr_err);
   end

   // Signature: fold active pixels, hand the result over at each frame edge.
   always_comb begin
      acc_d = acc_q;
      sig_d = sig_q;
      if (vs_lead) begin
         sig_d = acc_q;
         acc_d = SIG_INIT;
      end else if (active) begin
         acc_d = sig_step(acc_q, pix);
      end
   end

   // Lock FSM next state plus frame_done / frame_count updates.
   always_comb begin
      state_d = state_q;
      fd_d    = 1'b0;
      fc_d    = fc_q;
      case (state_q)
         HUNT: begin
            if (vs_lead) state_d = MEASURE;
         end
         MEASURE: begin
            if (h_bad || v_bad) begin
               state_d = HUNT;
            end else if (vs_lead) begin
               state_d = LOCKED;
               fd_d    = 1'b1;
               fc_d    = 8'd0;
            end
         end
         LOCKED: begin
            if (h_bad || v_bad) begin
               state_d = HUNT;
            end else if (vs_lead) begin
               fd_d = 1'b1;
               fc_d = fc_q + 8'd1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // State, counters, signature and flags; synchronous reset discards all
   // partial measurements.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         vin_q       <= VGA_IDLE;
         hs_prev_q   <= 1'b0;
         vs_prev_q   <= 1'b0;
         hcnt_q      <= 12'd0;
         vcnt_q      <= 12'd0;
         acc_q       <= SIG_INIT;
         sig_q       <= 16'd0;
         err_h_q     <= 1'b0;
         err_v_q     <= 1'b0;
         err_blank_q <= 1'b0;
         fd_q        <= 1'b0;
         fc_q        <= 8'd0;
      end else begin
         state_q     <= state_d;
         vin_q       <= mon.vga_in;
         hs_prev_q   <= hs;
         vs_prev_q   <= vs_prev_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         acc_q       <= acc_d;
         sig_q       <= sig_d;
         err_h_q     <= err_h_d;
         err_v_q     <= err_v_d;
         err_blank_q <= err_blank_d;
         fd_q        <= fd_d;
         fc_q        <= fc_d;
      end
   end

   assign mon.locked      = (state_q == LOCKED);
   assign mon.err_h       = err_h_q;
   assign mon.err_v       = err_v_q;
   assign mon.err_blank   = err_blank_q;
   assign mon.frame_done  = fd_q;
   assign mon.frame_sig   = sig_q;
   assign mon.frame_count = fc_q;

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Directed bench for vga_stream_monitor on a reduced 20x10 timing
// (12x6 active). Frames are generated back to back; checks are made at
// frame ends and at the reset pulse. Expected signatures: solid 0x3F gives
// 72*63 = 0x11B8, the incrementing pattern (k mod 64) gives 2016+28 = 0x07FC;
// with VGA_MON_CRC_EN a bitwise CRC-16-CCITT reference supplies both.
module tb_vga_stream_monitor;

   localparam int H_ACTIVE = 12;
   localparam int H_BP     = 2;
   localparam int H_SYNC   = 2;
   localparam int H_TOTAL  = 20;
   localparam int V_ACTIVE = 6;
   localparam int V_BP     = 1;
   localparam int V_SYNC   = 1;
   localparam int V_TOTAL  = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   fd_cnt = 0;

   vga_stream_monitor_if mon_if ();

   vga_stream_monitor #(
      .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
      .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (mon_if)
   );

   always #5 clk = ~clk;

   // Count frame_done high cycles away from the active edge.
   always @(negedge clk) if (mon_if.frame_done === 1'b1) fd_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] exp_sig(input int mode);
`ifdef VGA_MON_CRC_EN
      logic [15:0] crc;
      logic [5:0]  d;
      logic        fb;
      crc = 16'hFFFF;
      for (int k = 0; k < H_ACTIVE * V_ACTIVE; k++) begin
         d = (mode != 0) ? 6'(k % 64) : 6'h3F;
         for (int b = 5; b >= 0; b--) begin
            fb  = crc[15] ^ d[b];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ 16'h1021;
         end
      end
      return crc;
`else
      return (mode != 0) ? 16'h07FC : 16'h11B8;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send one frame. short_y: line sent one clock short; bad_idx: pixel
   // index forced to p=0x01; clr_idx / rst_idx: pixel index during which
   // clr_err / rst are held high. mode 0 = solid 0x3F, 1 = incrementing.
   task automatic send_frame(input int lines, input int short_y, input int mode,
                             input int bad_idx, input int clr_idx, input int rst_idx);
      int          idx;
      int          k;
      int          xmax;
      logic        hsn, vsn;
      logic [5:0]  p;
      idx = 0;
      k   = 0;
      for (int y = 0; y < lines; y++) begin
         xmax = (y == short_y) ? H_TOTAL - 1 : H_TOTAL;
         for (int x = 0; x < xmax; x++) begin
            hsn = (x < H_SYNC) ? 1'b0 : 1'b1;
            vsn = (y < V_SYNC) ? 1'b0 : 1'b1;
            p   = 6'd0;
            if (x >= H_SYNC + H_BP && x < H_SYNC + H_BP + H_ACTIVE &&
                y >= V_SYNC + V_BP && y < V_SYNC + V_BP + V_ACTIVE) begin
               p = (mode != 0) ? 6'(k % 64) : 6'h3F;
               k++;
            end
            if (idx == bad_idx) p = 6'h01;
            mon_if.vga_in  = {hsn, p[0], p[2], p[4], vsn, p[1], p[3], p[5]};
            mon_if.clr_err = (idx == clr_idx);
            rst            = (idx == rst_idx);
            step();
            if (idx == rst_idx) begin
               chk("rst_locked", {31'd0, mon_if.locked}, 0);
               chk("rst_err_h", {31'd0, mon_if.err_h}, 0);
               chk("rst_err_v", {31'd0, mon_if.err_v}, 0);
               chk("rst_err_blank", {31'd0, mon_if.err_blank}, 0);
               chk("rst_frame_done", {31'd0, mon_if.frame_done}, 0);
               chk("rst_frame_sig", {16'd0, mon_if.frame_sig}, 0);
               chk("rst_frame_count", {24'd0, mon_if.frame_count}, 0);
            end
            idx++;
         end
      end
      mon_if.clr_err = 1'b0;
      rst            = 1'b0;
   endtask

   initial begin
      mon_if.vga_in  = 8'h88;
      mon_if.clr_err = 1'b0;
      rst            = 1'b1;
      repeat (3) step();
      chk("reset_locked", {31'd0, mon_if.locked}, 0);
      chk("reset_errs", {29'd0, mon_if.err_h, mon_if.err_v, mon_if.err_blank}, 0);
      chk("reset_frame_done", {31'd0, mon_if.frame_done}, 0);
      chk("reset_sig", {16'd0, mon_if.frame_sig}, 0);
      chk("reset_count", {24'd0, mon_if.frame_count}, 0);
      rst = 1'b0;
      repeat (4) step();

      // Clean solid stream: lock at the 2nd vs edge, count 0,1,2.
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F1
      chk("f1_locked", {31'd0, mon_if.locked}, 0);
      chk("f1_fd", fd_cnt, 0);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F2
      chk("f2_locked", {31'd0, mon_if.locked}, 1);
      chk("f2_count", {24'd0, mon_if.frame_count}, 0);
      chk("f2_sig", {16'd0, mon_if.frame_sig}, {16'd0, exp_sig(0)});
      chk("f2_fd", fd_cnt, 1);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F3
      chk("f3_count", {24'd0, mon_if.frame_count}, 1);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F4
      chk("f4_count", {24'd0, mon_if.frame_count}, 2);
      chk("f4_fd", fd_cnt, 3);
      chk("f4_errs", {29'd0, mon_if.err_h, mon_if.err_v, mon_if.err_blank}, 0);

      // Short line: err_h, lock lost, relock after two clean edges.
      send_frame(V_TOTAL, 3, 0, -1, -1, -1);                   // F5
      chk("f5_err_h", {31'd0, mon_if.err_h}, 1);
      chk("f5_locked", {31'd0, mon_if.locked}, 0);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F6
      chk("f6_locked", {31'd0, mon_if.locked}, 0);
      chk("f6_err_h_sticky", {31'd0, mon_if.err_h}, 1);
      send_frame(V_TOTAL, -1, 0, -1, 50, -1);                  // F7
      chk("f7_locked", {31'd0, mon_if.locked}, 1);
      chk("f7_count", {24'd0, mon_if.frame_count}, 0);
      chk("f7_err_h_clr", {31'd0, mon_if.err_h}, 0);
      chk("f7_fd", fd_cnt, 5);

      // Short frame: err_v, lock lost, clr_err clears it on a clean stream.
      send_frame(V_TOTAL - 1, -1, 0, -1, -1, -1);              // F8
      chk("f8_count", {24'd0, mon_if.frame_count}, 1);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F9
      chk("f9_err_v", {31'd0, mon_if.err_v}, 1);
      chk("f9_locked", {31'd0, mon_if.locked}, 0);
      chk("f9_fd", fd_cnt, 6);
      send_frame(V_TOTAL, -1, 0, -1, 100, -1);                 // F10
      chk("f10_err_v_clr", {31'd0, mon_if.err_v}, 0);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F11
      chk("f11_locked", {31'd0, mon_if.locked}, 1);
      chk("f11_count", {24'd0, mon_if.frame_count}, 0);

      // Non-black pixel in hsync while locked, clr_err in the same cycle.
      send_frame(V_TOTAL, -1, 0, 5 * H_TOTAL, 5 * H_TOTAL + 1, -1);  // F12
      chk("f12_err_blank", {31'd0, mon_if.err_blank}, 1);
      chk("f12_locked", {31'd0, mon_if.locked}, 1);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F13
      chk("f13_sig", {16'd0, mon_if.frame_sig}, {16'd0, exp_sig(0)});
      chk("f13_locked", {31'd0, mon_if.locked}, 1);
      chk("f13_count", {24'd0, mon_if.frame_count}, 2);

      // Reset mid-frame: outputs clear, relock only at the 2nd later edge.
      send_frame(V_TOTAL, -1, 0, -1, -1, 100);                 // F14
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F15
      chk("f15_locked", {31'd0, mon_if.locked}, 0);
      chk("f15_fd", fd_cnt, 10);
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F16
      chk("f16_locked", {31'd0, mon_if.locked}, 1);
      chk("f16_count", {24'd0, mon_if.frame_count}, 0);
      chk("f16_sig", {16'd0, mon_if.frame_sig}, {16'd0, exp_sig(0)});

      // Incrementing pattern signature.
      send_frame(V_TOTAL, -1, 1, -1, -1, -1);                  // F17
      send_frame(V_TOTAL, -1, 0, -1, -1, -1);                  // F18
      chk("f18_sig_inc", {16'd0, mon_if.frame_sig}, {16'd0, exp_sig(1)});
      chk("f18_count", {24'd0, mon_if.frame_count}, 2);
      chk("f18_errs", {29'd0, mon_if.err_h, mon_if.err_v, mon_if.err_blank}, 0);
      chk("f18_fd", fd_cnt, 13);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_stream_monitor.md
Name: vga_stream_monitor

Overview:
- Receiver end of the TinyVGA PMOD output of the bouncy capsule design.
- Consumes the 8-bit uo_out bus (sync plus 2-bit RGB).
- Recovers and checks the timing, flags blanking violations, and produces a per-frame pixel signature so benches and on-board self-test logic can confirm the video stream is correct.
- Same clock domain as the generator; one pixel per clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_BP, 48, horizontal back porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_TOTAL, 800, clocks per line (all counters 12 bits, H_TOTAL and V_TOTAL ≤ 4095)
- V_ACTIVE, 480, visible lines per frame
- V_BP, 33, vertical back porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_TOTAL, 525, lines per frame
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vga_in  in  8  PMOD bus: [7]=hsync, [6]=B0, [5]=G0, [4]=R0, [3]=vsync, [2]=B1, [1]=G1, [0]=R1
- clr_err  in  1  clears the sticky error flags
- locked  out  1  timing verified for the last full frame
- err_h  out  1  sticky: line length or hsync width mismatch
- err_v  out  1  sticky: frame length or vsync width mismatch
- err_blank  out  1  sticky: nonzero RGB outside the active region while locked
- frame_done  out  1  one-cycle pulse at each frame boundary
- frame_sig  out  16  signature of the last completed frame
- frame_count  out  8  completed frames since lock, wraps at 255→0

Behaviour:
- Input stage:
  - vga_in is registered once; all logic uses the registered copy.
  - Pixel p is the 6-bit value {R1,R0,G1,G0,B1,B0}.
  - hs and vs are true when the sync bits equal SYNC_ACTIVE.
- Horizontal:
  - A leading edge (hs_lead) is hs true now and false on the previous registered cycle.
  - hcnt is set to 0 on hs_lead and otherwise increments, saturating at 4095.
  - On hs_lead outside HUNT, the previous hcnt must be H_TOTAL-1, else err_h.
  - On the first cycle hs is false after a lead, hcnt must equal H_SYNC, else err_h.
- Vertical:
  - vs is sampled only on hs_lead.
  - A vertical leading edge (vs_lead) is vs true at this hs_lead and false at the previous one.
  - vcnt is set to 0 on vs_lead and otherwise increments on each hs_lead.
  - On vs_lead outside HUNT, the previous vcnt must be V_TOTAL-1, else err_v.
  - At the first hs_lead with vs false, vcnt must equal V_SYNC, else err_v.
- Active region: H_SYNC+H_BP ≤ hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP ≤ vcnt < V_SYNC+V_BP+V_ACTIVE.
- Signature:
  - acc starts at 0 and accumulates p over active pixels, mod 2^16.
  - On vs_lead: frame_sig ← acc, acc ← 0, frame_done pulses one cycle later than vs_lead (registered).
- State machine:
  - HUNT: counters run, checks suppressed, no frame_done. On vs_lead → MEASURE.
  - MEASURE: checks enabled. On vs_lead with no error raised since entry → LOCKED, frame_done pulses, frame_count ← 0. Any error → HUNT.
  - LOCKED: locked=1. On each vs_lead, frame_done pulses and frame_count increments. Any error → HUNT, locked=0 on the next cycle.
- err_blank: in LOCKED, p≠0 outside the active region sets err_blank but does not drop lock.
- Sticky flags:
  - Flags stay set until clr_err.
  - When clr_err and a new error coincide, the new error wins (flag stays 1).
- Reset values:
  - All outputs 0, state HUNT, acc 0.
  - Reset mid-frame discards partial measurements; relock requires two subsequent vs_lead.

Optional Feature:
- Macro: VGA_MON_CRC_EN.
- Defined: the accumulator becomes CRC-16-CCITT.
  - Polynomial 0x1021, init 0xFFFF.
  - Each active pixel shifts in 6 bits, MSB (R1) first, in one clock.
  - frame_sig holds the final CRC with no reflection and no final XOR.
- Undefined: additive sum as described in Behaviour.

Test Plan:
- Clean 640x480 stream, solid p=0x3F in active region, 0 elsewhere → locked=1 after 2nd vs_lead; frame_sig=0x5000; err_* all 0; frame_count increments 0,1,2.
- One line of 799 clocks in frame 3 → err_h=1, locked=0; relock after two clean vs_lead edges; frame_count restarts at 0.
- Frame of 524 lines → err_v=1, lock lost; assert clr_err one cycle → err_v=0 while the stream continues clean.
- p=0x01 at hcnt=0 (in sync) while locked → err_blank=1, locked stays 1, frame_sig unchanged from expected.
- rst pulsed mid-frame → all outputs 0 the next cycle; locked returns only after the second following vs_lead.
- Reduced params (H_TOTAL=20, H_SYNC=2, H_BP=2, H_ACTIVE=12, V_TOTAL=10, V_SYNC=1, V_BP=1, V_ACTIVE=6), incrementing pixel pattern, with VGA_MON_CRC_EN on and off → frame_sig matches the bench reference model for both.
